// File: rtl/cache_ctrl_pkg.sv
// rtl/cache_ctrl_pkg.sv - shared state codes and geometry helpers for cache_ctrl_core
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_LOOKUP  = 3'd2,
    ST_RD_MEM  = 3'd3,
    ST_RD_RESP = 3'd4,
    ST_WR_MEM  = 3'd5
  } state_e;

  // Top nibble of the MMIO window that bypasses the cache when uncached mode is built in
  localparam logic [3:0] MMIO_REGION = 4'hF;

  function automatic int tag_width(input int addr_width, input int index_bits);
    return addr_width - index_bits - 2;
  endfunction

  function automatic int line_count(input int index_bits);
    return 1 << index_bits;
  endfunction

endpackage

// File: rtl/cache_ctrl_line_ram.sv
// rtl/cache_ctrl_line_ram.sv - 1R1W synchronous line store {valid, tag, data} with byte-enabled data writes
module cache_ctrl_line_ram
  import cache_ctrl_pkg::*;
#(
  parameter int INDEX_BITS = 8,
  parameter int TAG_W      = 22
) (
  input  logic                  clk,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [31:0]           rd_data,
  input  logic                  we,
  input  logic [INDEX_BITS-1:0] wr_idx,
  input  logic                  wr_valid,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_be
);

  localparam int DEPTH = line_count(INDEX_BITS);

  logic              valid_mem [DEPTH];
  logic [TAG_W-1:0]  tag_mem   [DEPTH];
  logic [31:0]       data_mem  [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      valid_mem[wr_idx] <= wr_valid;
      tag_mem[wr_idx]   <= wr_tag;
      for (int b = 0; b < 4; b++) begin
        if (wr_be[b]) data_mem[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    rd_valid <= valid_mem[rd_idx];
    rd_tag   <= tag_mem[rd_idx];
    rd_data  <= data_mem[rd_idx];
  end

endmodule

// File: rtl/cache_ctrl_core.sv
// rtl/cache_ctrl_core.sv - direct-mapped write-through no-allocate cache; CACHE_CTRL_UNCACHED_EN adds an MMIO bypass window
module cache_ctrl_core
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int INDEX_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst_x,
  input  logic [31:0]           d_pc,
  input  logic                  i_rd_en,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_data,
  input  logic [3:0]            i_mask,
  output logic [31:0]           o_data,
  output logic                  o_busy,
  output logic                  c_oe,
  output logic                  w_init_done,
  output logic [6:0]            state,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack
);

  localparam int TAG_W = tag_width(ADDR_WIDTH, INDEX_BITS);
  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam logic [INDEX_BITS-1:0] IDX_ONE = 1;

  state_e                state_q, state_d;
  logic [WA_W-1:0]       addr_q;
  logic [31:0]           wdata_q, rdata_q;
  logic [3:0]            wmask_q;
  logic [INDEX_BITS-1:0] init_idx;

  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [31:0]           rd_data;
  logic [INDEX_BITS-1:0] ram_rd_idx, ram_wr_idx;
  logic                  ram_we, ram_wr_valid;
  logic [31:0]           ram_wr_data;
  logic [3:0]            ram_wr_be;

  logic uncached, line_hit, accept, take_wr, take_rd;
  logic unused_inputs;

  wire [INDEX_BITS-1:0] addr_idx = addr_q[INDEX_BITS-1:0];
  wire [TAG_W-1:0]      addr_tag = addr_q[WA_W-1:INDEX_BITS];
  wire [INDEX_BITS-1:0] in_idx   = i_addr[INDEX_BITS+1:2];

  assign unused_inputs = ^{d_pc, i_addr[1:0]};

`ifdef CACHE_CTRL_UNCACHED_EN
  assign uncached = (addr_q[WA_W-1 -: 4] == MMIO_REGION);
`else
  assign uncached = 1'b0;
`endif

  // RAM output always reflects the line of addr_q once a request has been taken
  assign line_hit = rd_valid && (rd_tag == addr_tag) && !uncached;
  assign accept   = (state_q == ST_IDLE) || (state_q == ST_RD_RESP) ||
                    ((state_q == ST_LOOKUP) && line_hit);
  assign take_wr  = accept && i_wr_en;
  assign take_rd  = accept && i_rd_en && !i_wr_en;

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) state_q <= ST_INIT;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      init_idx <= '0;
    end else begin
      if (state_q == ST_INIT) init_idx <= init_idx + IDX_ONE;
      if (take_wr || take_rd) addr_q <= i_addr[ADDR_WIDTH-1:2];
      if (take_wr) begin
        wdata_q <= i_data;
        wmask_q <= i_mask;
      end
      if ((state_q == ST_RD_MEM) && mem_ack) rdata_q <= mem_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:    if (init_idx == '1) state_d = ST_IDLE;
      ST_IDLE, ST_LOOKUP, ST_RD_RESP: begin
        if ((state_q == ST_LOOKUP) && !line_hit) state_d = ST_RD_MEM;
        else if (take_wr)                        state_d = ST_WR_MEM;
        else if (take_rd)                        state_d = ST_LOOKUP;
        else                                     state_d = ST_IDLE;
      end
      ST_RD_MEM:  if (mem_ack) state_d = ST_RD_RESP;
      ST_WR_MEM:  if (mem_ack) state_d = ST_IDLE;
      default:    state_d = ST_INIT;
    endcase
  end

  always_comb begin
    o_busy      = !accept;
    c_oe        = ((state_q == ST_LOOKUP) && line_hit) || (state_q == ST_RD_RESP);
    o_data      = (state_q == ST_LOOKUP) ? rd_data : rdata_q;
    w_init_done = (state_q != ST_INIT);
    state       = 7'(state_q);
    mem_req     = (state_q == ST_RD_MEM) || (state_q == ST_WR_MEM);
    mem_we      = (state_q == ST_WR_MEM);
    mem_addr    = mem_req ? {addr_q, 2'b00} : '0;
    mem_wdata   = mem_we ? wdata_q : '0;
    mem_wmask   = mem_we ? wmask_q : ((state_q == ST_RD_MEM) ? 4'hF : 4'h0);

    ram_rd_idx   = (take_wr || take_rd) ? in_idx : addr_idx;
    ram_we       = 1'b0;
    ram_wr_idx   = addr_idx;
    ram_wr_valid = 1'b1;
    ram_wr_data  = mem_rdata;
    ram_wr_be    = 4'h0;
    if (state_q == ST_INIT) begin
      ram_we       = 1'b1;
      ram_wr_idx   = init_idx;
      ram_wr_valid = 1'b0;
    end else if ((state_q == ST_RD_MEM) && mem_ack && !uncached) begin
      ram_we    = 1'b1;
      ram_wr_be = 4'hF;
    end else if ((state_q == ST_WR_MEM) && mem_ack && line_hit) begin
      ram_we      = 1'b1;
      ram_wr_data = wdata_q;
      ram_wr_be   = wmask_q;
    end
  end

  cache_ctrl_line_ram #(
    .INDEX_BITS (INDEX_BITS),
    .TAG_W      (TAG_W)
  ) u_line_ram (
    .clk      (clk),
    .rd_idx   (ram_rd_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (ram_we),
    .wr_idx   (ram_wr_idx),
    .wr_valid (ram_wr_valid),
    .wr_tag   (addr_tag),
    .wr_data  (ram_wr_data),
    .wr_be    (ram_wr_be)
  );

endmodule

// File: tb/tb_cache_ctrl_core.sv
// tb/tb_cache_ctrl_core.sv - directed self-checking bench for cache_ctrl_core
module tb_cache_ctrl_core;

  logic        clk = 1'b0;
  logic        rst_x = 1'b0;
  logic [31:0] d_pc = 32'h0;
  logic        i_rd_en = 1'b0, i_wr_en = 1'b0;
  logic [31:0] i_addr = 32'h0, i_data = 32'h0;
  logic [3:0]  i_mask = 4'h0;
  logic [31:0] o_data;
  logic        o_busy, c_oe, w_init_done;
  logic [6:0]  state;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int checks = 0;
  int failures = 0;

  int          lat = 5;
  int          rd_cnt = 0, wr_cnt = 0;
  logic [31:0] last_addr = 32'h0, last_wdata = 32'h0;
  logic [3:0]  last_wmask = 4'h0, last_rmask = 4'h0;
  logic [31:0] bmem [logic [31:0]];

  always #5 clk = ~clk;

  cache_ctrl_core dut (
    .clk(clk), .rst_x(rst_x), .d_pc(d_pc), .i_rd_en(i_rd_en), .i_wr_en(i_wr_en),
    .i_addr(i_addr), .i_data(i_data), .i_mask(i_mask), .o_data(o_data), .o_busy(o_busy),
    .c_oe(c_oe), .w_init_done(w_init_done), .state(state), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (bmem.exists(a)) return bmem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Backing memory: acks `lat` cycles after a request is seen, applies masked writes
  initial begin
    int wcnt;
    logic [31:0] cur;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_x || mem_ack) begin
        mem_ack = 1'b0;
        wcnt = 0;
      end else if (mem_req) begin
        wcnt++;
        if (wcnt >= lat) begin
          mem_ack = 1'b1;
          last_addr = mem_addr;
          if (mem_we) begin
            wr_cnt++;
            last_wdata = mem_wdata;
            last_wmask = mem_wmask;
            cur = mem_read(mem_addr);
            for (int b = 0; b < 4; b++)
              if (mem_wmask[b]) cur[8*b +: 8] = mem_wdata[8*b +: 8];
            bmem[mem_addr] = cur;
          end else begin
            rd_cnt++;
            last_rmask = mem_wmask;
            mem_rdata = mem_read(mem_addr);
          end
        end
      end
    end
  end

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output int n,
                         output logic busy1, output logic ack_prev);
    logic prev;
    @(negedge clk);
    i_addr = addr;
    i_rd_en = 1'b1;
    @(negedge clk);
    i_rd_en = 1'b0;
    n = 1;
    busy1 = o_busy;
    prev = 1'b0;
    while (!c_oe && n < 200) begin
      prev = mem_ack;
      @(negedge clk);
      n++;
    end
    data = o_data;
    ack_prev = prev;
    checks++;
    if (!c_oe) begin
      failures++;
      $display("FAIL read_timeout addr=%h: c_oe=%b after %0d cycles, required 1", addr, c_oe, n);
    end
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                          input logic rd_too, output logic busy_first, output logic fall_after_ack);
    logic prev;
    int n;
    @(negedge clk);
    i_addr = addr;
    i_data = data;
    i_mask = mask;
    i_wr_en = 1'b1;
    i_rd_en = rd_too;
    @(negedge clk);
    busy_first = o_busy;
    i_wr_en = 1'b0;
    i_rd_en = 1'b0;
    n = 0;
    prev = 1'b0;
    while (o_busy && n < 200) begin
      prev = mem_ack;
      @(negedge clk);
      n++;
    end
    fall_after_ack = !o_busy && prev;
    checks++;
    if (o_busy) begin
      failures++;
      $display("FAIL write_timeout addr=%h: o_busy=%b, required 0", addr, o_busy);
    end
  endtask

  task automatic release_and_wait(output int n);
    rst_x = 1'b1;
    n = 1;
    @(negedge clk);
    while (o_busy && n < 1000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_x = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (state !== 7'd0) begin failures++; $display("FAIL reset_state: got %0d required 0", state); end
    checks++; if (o_busy !== 1'b1) begin failures++; $display("FAIL reset_busy: got %b required 1", o_busy); end
    checks++; if ({w_init_done, c_oe} !== 2'b00) begin failures++; $display("FAIL reset_done_oe: got %b required 00", {w_init_done, c_oe}); end
    checks++; if (o_data !== 32'h0) begin failures++; $display("FAIL reset_odata: got %h required 0", o_data); end
    checks++; if ({mem_req, mem_we, mem_wmask} !== 6'h0) begin failures++; $display("FAIL reset_mem_ctl: got %h required 0", {mem_req, mem_we, mem_wmask}); end
    checks++; if ({mem_addr, mem_wdata} !== 64'h0) begin failures++; $display("FAIL reset_mem_bus: got %h required 0", {mem_addr, mem_wdata}); end
  endtask

  task automatic test_init();
    int n;
    release_and_wait(n);
    checks++; if (n !== 256) begin failures++; $display("FAIL init_cycles: got %0d required 256", n); end
    checks++; if ({w_init_done, o_busy} !== 2'b10) begin failures++; $display("FAIL init_done_busy: got %b required 10", {w_init_done, o_busy}); end
    checks++; if (state !== 7'd1) begin failures++; $display("FAIL init_idle_state: got %0d required 1", state); end
  endtask

  task automatic test_read_miss_hit();
    logic [31:0] d; int n, r0; logic b1, ap;
    bmem[32'h100] = 32'hDEAD_BEEF;
    r0 = rd_cnt;
    do_read(32'h100, d, n, b1, ap);
    checks++; if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL miss_data: got %h required deadbeef", d); end
    checks++; if (rd_cnt - r0 !== 1) begin failures++; $display("FAIL miss_mem_reads: got %0d required 1", rd_cnt - r0); end
    checks++; if ({b1, ap} !== 2'b11) begin failures++; $display("FAIL miss_busy_ack_timing: got %b required 11", {b1, ap}); end
    checks++; if ({last_addr, last_rmask} !== {32'h100, 4'hF}) begin failures++; $display("FAIL miss_mem_addr_mask: got %h required 100f", {last_addr, last_rmask}); end
    r0 = rd_cnt;
    do_read(32'h100, d, n, b1, ap);
    checks++; if (d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL hit_data: got %h required deadbeef", d); end
    checks++; if (n !== 1) begin failures++; $display("FAIL hit_latency: got %0d required 1", n); end
    checks++; if ({b1, rd_cnt - r0} !== {1'b0, 32'd0}) begin failures++; $display("FAIL hit_busy_reads: busy=%b reads=%0d required 0 0", b1, rd_cnt - r0); end
  endtask

  task automatic test_partial_write();
    logic [31:0] d; int n, r0; logic b1, ap, bf, fa;
    do_write(32'h100, 32'h1122_3344, 4'b0011, 1'b0, bf, fa);
    checks++; if ({last_wmask, last_wdata, last_addr} !== {4'h3, 32'h1122_3344, 32'h100}) begin failures++; $display("FAIL pwrite_backend: got %h required 311223344_00000100", {last_wmask, last_wdata, last_addr}); end
    checks++; if ({bf, fa} !== 2'b11) begin failures++; $display("FAIL pwrite_busy_timing: got %b required 11", {bf, fa}); end
    r0 = rd_cnt;
    do_read(32'h100, d, n, b1, ap);
    checks++; if (d !== 32'hDEAD_3344) begin failures++; $display("FAIL pwrite_merged: got %h required dead3344", d); end
    checks++; if (rd_cnt - r0 !== 0) begin failures++; $display("FAIL pwrite_no_refetch: got %0d required 0", rd_cnt - r0); end
  endtask

  task automatic test_write_miss();
    logic [31:0] d; int n, r0, w0; logic b1, ap, bf, fa;
    w0 = wr_cnt;
    do_write(32'h2000, 32'hCAFE_F00D, 4'hF, 1'b0, bf, fa);
    checks++; if (wr_cnt - w0 !== 1) begin failures++; $display("FAIL wmiss_forwarded: got %0d required 1", wr_cnt - w0); end
    r0 = rd_cnt;
    do_read(32'h2000, d, n, b1, ap);
    checks++; if (rd_cnt - r0 !== 1) begin failures++; $display("FAIL wmiss_no_allocate: got %0d required 1", rd_cnt - r0); end
    checks++; if (d !== 32'hCAFE_F00D) begin failures++; $display("FAIL wmiss_read_data: got %h required cafef00d", d); end
  endtask

  task automatic test_conflict();
    logic [31:0] d; int n, r0; logic b1, ap;
    r0 = rd_cnt;
    do_read(32'h204, d, n, b1, ap);
    do_read(32'h604, d, n, b1, ap);
    checks++; if (d !== 32'h5A5A_0604) begin failures++; $display("FAIL conflict_data2: got %h required 5a5a0604", d); end
    do_read(32'h204, d, n, b1, ap);
    checks++; if (rd_cnt - r0 !== 3) begin failures++; $display("FAIL conflict_reads: got %0d required 3", rd_cnt - r0); end
    checks++; if (d !== 32'h5A5A_0204) begin failures++; $display("FAIL conflict_data3: got %h required 5a5a0204", d); end
  endtask

  task automatic test_mask_edges();
    logic [31:0] d; int n, r0; logic b1, ap, bf, fa;
    do_write(32'h204, 32'hFFFF_FFFF, 4'b0000, 1'b0, bf, fa);
    checks++; if (last_wmask !== 4'h0) begin failures++; $display("FAIL zero_mask_backend: got %h required 0", last_wmask); end
    do_write(32'h204, 32'hAABB_CCDD, 4'b1010, 1'b0, bf, fa);
    r0 = rd_cnt;
    do_read(32'h204, d, n, b1, ap);
    checks++; if (d !== 32'hAA5A_CC04) begin failures++; $display("FAIL sparse_mask_merge: got %h required aa5acc04", d); end
    checks++; if (n !== 1 || rd_cnt - r0 !== 0) begin failures++; $display("FAIL sparse_mask_hit: latency=%0d reads=%0d required 1 0", n, rd_cnt - r0); end
  endtask

  task automatic test_wr_priority();
    logic [31:0] d; int n, r0, w0; logic b1, ap, bf, fa;
    r0 = rd_cnt; w0 = wr_cnt;
    do_write(32'h300, 32'h0102_0304, 4'hF, 1'b1, bf, fa);
    checks++; if ({wr_cnt - w0, rd_cnt - r0} !== {32'd1, 32'd0}) begin failures++; $display("FAIL wr_priority: writes=%0d reads=%0d required 1 0", wr_cnt - w0, rd_cnt - r0); end
    do_read(32'h300, d, n, b1, ap);
    checks++; if (d !== 32'h0102_0304) begin failures++; $display("FAIL wr_priority_data: got %h required 01020304", d); end
  endtask

  task automatic test_back_to_back();
    int r0;
    r0 = rd_cnt;
    @(negedge clk);
    i_addr = 32'h100;
    i_rd_en = 1'b1;
    @(negedge clk);
    checks++; if ({c_oe, o_data} !== {1'b1, 32'hDEAD_3344}) begin failures++; $display("FAIL b2b_first: got %b %h required 1 dead3344", c_oe, o_data); end
    i_addr = 32'h204;
    @(negedge clk);
    i_rd_en = 1'b0;
    checks++; if ({c_oe, o_data} !== {1'b1, 32'hAA5A_CC04}) begin failures++; $display("FAIL b2b_second: got %b %h required 1 aa5acc04", c_oe, o_data); end
    @(negedge clk);
    checks++; if ({c_oe, o_busy, rd_cnt - r0} !== {2'b00, 32'd0}) begin failures++; $display("FAIL b2b_settle: oe=%b busy=%b reads=%0d required 0 0 0", c_oe, o_busy, rd_cnt - r0); end
  endtask

  task automatic test_bypass();
    logic [31:0] d; int n, r0, exp_reads; logic b1, ap;
`ifdef CACHE_CTRL_UNCACHED_EN
    exp_reads = 2;
`else
    exp_reads = 1;
`endif
    r0 = rd_cnt;
    do_read(32'hF000_0000, d, n, b1, ap);
    do_read(32'hF000_0000, d, n, b1, ap);
    checks++; if (rd_cnt - r0 !== exp_reads) begin failures++; $display("FAIL bypass_reads: got %0d required %0d", rd_cnt - r0, exp_reads); end
    checks++; if (d !== 32'hAA5A_0000) begin failures++; $display("FAIL bypass_data: got %h required aa5a0000", d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; int n, r0; logic b1, ap;
    lat = 20;
    @(negedge clk);
    i_addr = 32'h3000;
    i_rd_en = 1'b1;
    @(negedge clk);
    i_rd_en = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if ({mem_req, state} !== {1'b1, 7'd3}) begin failures++; $display("FAIL mid_in_rd_mem: req=%b state=%0d required 1 3", mem_req, state); end
    rst_x = 1'b0;
    #1;
    checks++; if ({mem_req, o_busy, state} !== {2'b01, 7'd0}) begin failures++; $display("FAIL mid_async_reset: req=%b busy=%b state=%0d required 0 1 0", mem_req, o_busy, state); end
    @(negedge clk);
    lat = 5;
    release_and_wait(n);
    checks++; if (n !== 256) begin failures++; $display("FAIL mid_reinit_cycles: got %0d required 256", n); end
    r0 = rd_cnt;
    do_read(32'h100, d, n, b1, ap);
    checks++; if ({d, rd_cnt - r0} !== {32'hDEAD_3344, 32'd1}) begin failures++; $display("FAIL mid_lines_cleared: data=%h reads=%0d required dead3344 1", d, rd_cnt - r0); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_init();
    test_read_miss_hit();
    test_partial_write();
    test_write_miss();
    test_conflict();
    test_mask_edges();
    test_wr_priority();
    test_back_to_back();
    test_bypass();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
